// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller for the 4-bit ALU.
// It steps a single-position shifter once per clock to shift a nibble by 0..2^AMT_W-1 positions.
module shift_seq_ctrl #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [3:0]       din,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dout,
  output logic             carry,
  output logic             sticky,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       work_q, work_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             last_q, last_d;
  logic             sticky_acc_q, sticky_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       dout_q, dout_d;
  logic             carry_q, carry_d;
  logic             sticky_q, sticky_d;
  logic             zero_q, zero_d;

  logic             fill_bit;
  logic [3:0]       shift_out;
  logic             shift_off;

  // Single-position shifter: fill bit enters at the vacated end, the other end falls off.
  always_comb begin
    fill_bit = 1'b0;
    case (mode_q)
      MODE_LOGIC: fill_bit = 1'b0;
      MODE_ONES:  fill_bit = 1'b1;
      MODE_ARITH: fill_bit = dir_q ? work_q[3] : 1'b0;
      MODE_ROT:   fill_bit = dir_q ? work_q[0] : work_q[3];
      default:    fill_bit = 1'b0;
    endcase
    if (dir_q) begin
      shift_out = {fill_bit, work_q[3:1]};
      shift_off = work_q[0];
    end else begin
      shift_out = {work_q[2:0], fill_bit};
      shift_off = work_q[3];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    last_d       = last_q;
    sticky_acc_d = sticky_acc_q;
    dout_d       = dout_q;
    carry_d      = carry_q;
    sticky_d     = sticky_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d       = din;
          cnt_d        = amt;
          dir_d        = dir;
          mode_d       = mode;
          last_d       = 1'b0;
          sticky_acc_d = 1'b0;
          if (amt == '0) begin
            state_d  = DONE;
            dout_d   = din;
            carry_d  = 1'b0;
            sticky_d = 1'b0;
            zero_d   = (din == 4'b0000);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d       = shift_out;
        last_d       = shift_off;
        sticky_acc_d = sticky_acc_q | shift_off;
        cnt_d        = cnt_q - CNT_ONE;
        // Results publish on the same edge as the final step, so they use the next-state values.
        if (cnt_q == CNT_ONE) begin
          state_d  = DONE;
          dout_d   = shift_out;
          carry_d  = last_d;
          sticky_d = sticky_acc_d;
          zero_d   = (shift_out == 4'b0000);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_q       <= 4'b0000;
      dir_q        <= 1'b0;
      mode_q       <= MODE_LOGIC;
      last_q       <= 1'b0;
      sticky_acc_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= 4'b0000;
      carry_q      <= 1'b0;
      sticky_q     <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      last_q       <= last_d;
      sticky_acc_q <= sticky_acc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      carry_q      <= carry_d;
      sticky_q     <= sticky_d;
      zero_q       <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign dout   = dout_q;
  assign carry  = carry_q;
  assign sticky = sticky_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes hand-computed results and due cycles,
// a monitor pops and compares on every done pulse.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [2:0] amt;
  logic [3:0] din;
  logic       busy;
  logic       done;
  logic [3:0] dout;
  logic       carry;
  logic       sticky;
  logic       zero;

  typedef struct {
    string      name;
    logic [3:0] dout;
    logic       carry;
    logic       sticky;
    logic       zero;
    int         dueCycle;
  } exp_t;

  exp_t scoreboard[$];
  int   cycleCount = 0;
  int   doneCount  = 0;
  int   checks     = 0;
  int   fails      = 0;

  shift_seq_ctrl #(.AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .mode(mode), .amt(amt), .din(din),
    .busy(busy), .done(done), .dout(dout), .carry(carry), .sticky(sticky), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneCount++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput({e.name, ".dout"},   int'(dout),   int'(e.dout));
        checkOutput({e.name, ".carry"},  int'(carry),  int'(e.carry));
        checkOutput({e.name, ".sticky"}, int'(sticky), int'(e.sticky));
        checkOutput({e.name, ".zero"},   int'(zero),   int'(e.zero));
        checkOutput({e.name, ".busy"},   int'(busy),   1);
        checkOutput({e.name, ".cycle"},  cycleCount,   e.dueCycle);
      end
    end
  end

  task automatic pushExpected(input string name, input logic [3:0] d, input logic c,
                              input logic s, input logic z, input int due);
    exp_t e;
    e.name = name; e.dout = d; e.carry = c; e.sticky = s; e.zero = z; e.dueCycle = due;
    scoreboard.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (scoreboard.size() == 0) break;
    end
    if (scoreboard.size() != 0) begin
      checkOutput({name, ".timeout"}, scoreboard.size(), 0);
      scoreboard.delete();
    end
  endtask

  task automatic applyStimulus(input string name, input logic d, input logic [1:0] m,
                               input logic [2:0] a, input logic [3:0] x,
                               input logic [3:0] expDout, input logic expCarry,
                               input logic expSticky, input logic expZero);
    @(negedge clk);
    dir = d; mode = m; amt = a; din = x; start = 1'b1;
    @(posedge clk);
    #1;
    pushExpected(name, expDout, expCarry, expSticky, expZero, cycleCount + int'(a));
    @(negedge clk);
    start = 1'b0;
    din   = ~x;
    amt   = ~a;
    waitIdle(name);
  endtask

  logic [3:0] hsPattern [8];
  int         acceptCycle;
  int         doneBefore;

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amt = 3'd0; din = 4'b0000;
    hsPattern = '{4'b0011, 4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b1110, 4'b0111, 4'b0100};
    repeat (2) @(negedge clk);
    checkOutput("reset.busy",   int'(busy),   0);
    checkOutput("reset.done",   int'(done),   0);
    checkOutput("reset.dout",   int'(dout),   0);
    checkOutput("reset.carry",  int'(carry),  0);
    checkOutput("reset.sticky", int'(sticky), 0);
    checkOutput("reset.zero",   int'(zero),   0);
    rst = 1'b0;

    applyStimulus("lslLeft1",   1'b0, 2'b00, 3'd1, 4'b1011, 4'b0110, 1'b1, 1'b1, 1'b0);
    applyStimulus("asrRight2",  1'b1, 2'b10, 3'd2, 4'b1010, 4'b1110, 1'b1, 1'b1, 1'b0);
    applyStimulus("aslLeft2",   1'b0, 2'b10, 3'd2, 4'b1011, 4'b1100, 1'b0, 1'b1, 1'b0);
    applyStimulus("rotLeft3",   1'b0, 2'b11, 3'd3, 4'b1001, 4'b1100, 1'b0, 1'b1, 1'b0);
    applyStimulus("rotLeft4",   1'b0, 2'b11, 3'd4, 4'b1001, 4'b1001, 1'b1, 1'b1, 1'b0);
    applyStimulus("amt0Arith",  1'b1, 2'b10, 3'd0, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0);
    applyStimulus("amt0Rot",    1'b0, 2'b11, 3'd0, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0);
    applyStimulus("lslLeft7",   1'b0, 2'b00, 3'd7, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b1);

    // start held high across a rotate-right-by-5 job while din changes every cycle
    @(negedge clk);
    dir = 1'b1; mode = 2'b11; amt = 3'd5; din = hsPattern[0]; start = 1'b1;
    @(posedge clk);
    #1;
    acceptCycle = cycleCount;
    pushExpected("hsJob1", 4'b1001, 1'b1, 1'b1, 1'b0, acceptCycle + 5);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      din = hsPattern[k];
    end
    @(posedge clk);
    #1;
    pushExpected("hsJob2", 4'b0010, 1'b0, 1'b1, 1'b0, acceptCycle + 7 + 5);
    @(negedge clk);
    start = 1'b0;
    waitIdle("handshake");

    applyStimulus("onesRight7", 1'b1, 2'b01, 3'd7, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);

    // reset during the second SHIFT cycle of an amt=5 job
    @(negedge clk);
    dir = 1'b0; mode = 2'b01; amt = 3'd5; din = 4'b1111; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    doneBefore = doneCount;
    checkOutput("midReset.busy",   int'(busy),   0);
    checkOutput("midReset.done",   int'(done),   0);
    checkOutput("midReset.dout",   int'(dout),   0);
    checkOutput("midReset.carry",  int'(carry),  0);
    checkOutput("midReset.sticky", int'(sticky), 0);
    checkOutput("midReset.zero",   int'(zero),   0);
    repeat (10) @(negedge clk);
    checkOutput("midReset.noDone", doneCount - doneBefore, 0);
    checkOutput("midReset.idle",   int'(busy),   0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
